// File: rtl/aes_mixcol_stage.sv
// aes_mixcol_stage: iterative AES MixColumns/InvMixColumns round stage with final-round bypass
module aes_mixcol_stage #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         decrypt_i,
  input  logic         bypass_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o,
  output logic         ready_o,
  output logic         busy_o
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);
  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate
  state_t state, state_n;
  logic [1:0] cnt;
  logic [2:0] cnt_n;
  logic [127:0] work;
  logic dec;
  logic accept;
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] c, input logic inv);
    logic [7:0] s [4];
    logic [7:0] s2 [4];
    logic [7:0] s4 [4];
    logic [7:0] s8 [4];
    logic [31:0] o;
    for (int r = 0; r < 4; r++) begin
      s[r]  = c[8*r +: 8];
      s2[r] = xt(s[r]);
      s4[r] = xt(s2[r]);
      s8[r] = xt(s4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      o[8*r +: 8] = inv
        ? (s8[r] ^ s4[r] ^ s2[r]) ^ (s8[(r+1)%4] ^ s2[(r+1)%4] ^ s[(r+1)%4]) ^
          (s8[(r+2)%4] ^ s4[(r+2)%4] ^ s[(r+2)%4]) ^ (s8[(r+3)%4] ^ s[(r+3)%4])
        : s2[r] ^ s2[(r+1)%4] ^ s[(r+1)%4] ^ s[(r+2)%4] ^ s[(r+3)%4];
    end
    return o;
  endfunction
  // a start coinciding with the completion pulse still counts as busy and is dropped
  assign accept = start_i && state == IDLE && !ready_o;
  assign cnt_n  = {1'b0, cnt} + STEP;
  assign busy_o = state != IDLE || ready_o;
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (accept ? (bypass_i ? DONE : CALC) : IDLE)
            : state == CALC ? (cnt_n[2] ? DONE : CALC)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      work    <= '0;
      dec     <= 1'b0;
      data_o  <= '0;
      ready_o <= 1'b0;
    end else begin
      state   <= state_n;
      ready_o <= state == DONE;
      if (accept) begin
        work <= data_i;
        dec  <= decrypt_i;
        cnt  <= 2'd0;
      end
      if (state == CALC) begin
        for (int j = 0; j < COLS_PER_CYCLE; j++)
          work[32*(int'(cnt)+j) +: 32] <= mix(work[32*(int'(cnt)+j) +: 32], dec);
        cnt <= cnt_n[1:0];
      end
      if (state == DONE) data_o <= work;
    end
  end
endmodule

// File: tb/tb_aes_mixcol_stage.sv
// tb_aes_mixcol_stage: scoreboard bench over three parameterisations sharing data/control inputs
module tb_aes_mixcol_stage;
  typedef struct {logic [127:0] d; int cyc;} exp_t;
  localparam logic [127:0] V_IN  = 128'h4c31262d_d5d4d4d4_5c220af2_455313db;
  localparam logic [127:0] V_OUT = 128'hf8bd7e4d_d6d7d5d5_9d58dc9f_bca14d8e;
  localparam logic [127:0] ONES  = {16{8'h01}};
  localparam logic [127:0] BP    = 128'h00112233445566778899aabbccddeeff;
  logic clk = 0, rst = 1;
  logic [2:0] start = 3'b000;
  logic decrypt_i = 0, bypass_i = 0;
  logic [127:0] data_i = '0;
  logic [127:0] dout [3];
  logic rdy [3];
  logic bsy [3];
  exp_t q [3][$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  aes_mixcol_stage #(.COLS_PER_CYCLE(1)) u1 (.clk(clk), .rst(rst), .start_i(start[0]), .decrypt_i(decrypt_i),
    .bypass_i(bypass_i), .data_i(data_i), .data_o(dout[0]), .ready_o(rdy[0]), .busy_o(bsy[0]));
  aes_mixcol_stage #(.COLS_PER_CYCLE(2)) u2 (.clk(clk), .rst(rst), .start_i(start[1]), .decrypt_i(decrypt_i),
    .bypass_i(bypass_i), .data_i(data_i), .data_o(dout[1]), .ready_o(rdy[1]), .busy_o(bsy[1]));
  aes_mixcol_stage #(.COLS_PER_CYCLE(4)) u4 (.clk(clk), .rst(rst), .start_i(start[2]), .decrypt_i(decrypt_i),
    .bypass_i(bypass_i), .data_i(data_i), .data_o(dout[2]), .ready_o(rdy[2]), .busy_o(bsy[2]));
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int k = 14; k >= 8; k--) if (p[k]) p ^= 15'(9'h11b) << (k - 8);
    return p[7:0];
  endfunction
  function automatic logic [127:0] model(input logic [127:0] d, input logic dec, input logic byp);
    logic [7:0] co [4];
    logic [127:0] o = '0;
    if (byp) return d;
    co = dec ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          o[32*c + 8*r +: 8] ^= gmul(co[k], d[32*c + 8*((r+k)%4) +: 8]);
    return o;
  endfunction
  function automatic int lat(input int i, input logic byp);
    return byp ? 2 : (i == 0 ? 6 : i == 1 ? 4 : 3);
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [127:0] d, input logic dec, input logic byp, input logic [127:0] e, input bit all);
    data_i = d; decrypt_i = dec; bypass_i = byp;
    start = all ? 3'b111 : 3'b001;
    for (int i = 0; i < 3; i++) if (all || i == 0) q[i].push_back(exp_t'{e, cyc + lat(i, byp)});
    @(posedge clk); #1;
    start = 3'b000;
    data_i = {$urandom, $urandom, $urandom, $urandom};
    decrypt_i = ~dec; bypass_i = ~byp;
  endtask
  task automatic wait_drain();
    int n = 0;
    while (q[0].size() != 0 || q[1].size() != 0 || q[2].size() != 0) begin
      @(posedge clk); #1;
      if (++n > 40) begin
        n_chk++; n_fail++;
        $display("FAIL ready_timeout: got no ready_o within 40 cycles, required pending=%0d/%0d/%0d",
                 q[0].size(), q[1].size(), q[2].size());
        for (int i = 0; i < 3; i++) q[i].delete();
      end
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) if (rdy[i] === 1'b1) begin
      n_chk++;
      if (q[i].size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ready dut%0d: got ready_o at cycle %0d, required none", i, cyc);
      end else begin
        e = q[i].pop_front();
        if (dout[i] !== e.d) begin
          n_fail++;
          $display("FAIL data dut%0d: got %h expected %h", i, dout[i], e.d);
        end
        n_chk++;
        if (cyc != e.cyc) begin
          n_fail++;
          $display("FAIL latency dut%0d: got ready_o at cycle %0d expected %0d", i, cyc, e.cyc);
        end
      end
    end
  end
  initial begin
    logic [127:0] d;
    logic dec, byp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_data%0d", i), dout[i], '0);
      chk($sformatf("reset_ready%0d", i), 128'(rdy[i]), '0);
      chk($sformatf("reset_busy%0d", i), 128'(bsy[i]), '0);
    end
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    issue(V_IN, 0, 0, V_OUT, 1); wait_drain();
    issue(V_OUT, 1, 0, V_IN, 1); wait_drain();
    issue(ONES, 0, 0, ONES, 1); wait_drain();
    issue(ONES, 1, 0, ONES, 1); wait_drain();
    issue(BP, 0, 1, BP, 1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("bypass_busy_t1_%0d", i), 128'(bsy[i]), 128'd1);
    @(posedge clk); #1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("bypass_busy_t2_%0d", i), 128'(bsy[i]), 128'd1);
    @(posedge clk); #1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("bypass_busy_t3_%0d", i), 128'(bsy[i]), 128'd0);
    wait_drain();
    issue(V_IN, 0, 0, V_OUT, 0);
    @(posedge clk); #1 start[0] = 1; data_i = BP; decrypt_i = 1;
    @(posedge clk); #1 start[0] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 start[0] = 1; data_i = ONES; bypass_i = 1;
    @(posedge clk); #1 start[0] = 0;
    @(posedge clk); #1;
    issue(V_OUT, 1, 0, V_IN, 0); wait_drain();
    issue(V_IN, 0, 0, V_OUT, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1; start[0] = 1; q[0].delete();
    @(posedge clk); #1 rst = 0; start[0] = 0;
    @(negedge clk);
    chk("abort_data", dout[0], '0);
    chk("abort_busy", 128'(bsy[0]), '0);
    chk("abort_ready", 128'(rdy[0]), '0);
    repeat (8) @(posedge clk);
    #1;
    for (int n = 0; n < 20; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      dec = 1'($urandom);
      byp = ($urandom % 4) == 0;
      issue(d, dec, byp, model(d, dec, byp), 1);
      wait_drain();
      repeat ($urandom % 3) @(posedge clk);
      #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_mixcol_stage.md
Name: aes_mixcol_stage

Overview:
- AES-128 round stage sitting directly downstream of the row-shift stage; consumes its 128-bit state and its start/ready handshake.
- Performs MixColumns (encrypt) or InvMixColumns (decrypt) on the captured state. Columns are processed iteratively, COLS_PER_CYCLE per cycle, to trade area for latency.
- A bypass input serves the final round, which has no MixColumns.
- Output feeds the AddRoundKey stage.

Parameters:
- COLS_PER_CYCLE, 1, columns computed per active cycle; legal values 1, 2, 4. Any other value is a compile-time error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous and active-high.
- start_i  in  1  one-cycle pulse: data_i/decrypt_i/bypass_i are valid.
- decrypt_i  in  1  1 = InvMixColumns, 0 = MixColumns; sampled with start_i.
- bypass_i  in  1  1 = final round, pass the state unchanged; sampled with start_i.
- data_i  in  128  state in; column c = data_i[32c+31:32c]; row r of a column = bits [8r+7:8r] of that word.
- data_o  out  128  result state, same layout as data_i; holds its value until the next completion.
- ready_o  out  1  one-cycle pulse: data_o is valid.
- busy_o  out  1  high from the cycle after an accepted start until ready_o inclusive.

Behaviour:
- Reset (rst high at a clk edge):
  - FSM to IDLE; column counter 0.
  - data_o, ready_o, busy_o, all internal state registers and captured control bits go to 0.
  - Reset mid-operation aborts the operation with no ready_o.
  - rst has priority over start_i in the same cycle.
- FSM has three states: IDLE, CALC, DONE.
  - IDLE: start_i=1 captures data_i into the work register and latches decrypt_i and bypass_i.
    - Next state is DONE if bypass_i=1, else CALC with counter=0.
  - CALC: each cycle transforms columns counter .. counter+COLS_PER_CYCLE-1 in place and advances counter by COLS_PER_CYCLE.
    - After the cycle that processes column 3, go to DONE. The counter wraps to 0.
  - DONE: data_o <= work register; ready_o=1 for exactly this cycle; next state is IDLE.
- Latency, where T = start cycle:
  - Non-bypass: ready_o at T+1+4/COLS_PER_CYCLE+1, i.e. T+6 / T+4 / T+3 for 1 / 2 / 4.
  - Bypass: ready_o at T+2, regardless of the parameter.
- Handshake:
  - start_i is accepted only in IDLE.
  - start_i while busy_o=1 (CALC or DONE) is ignored and does not disturb the operation in flight.
  - Back-to-back operation: start_i may be asserted in the cycle after ready_o.
  - decrypt_i and bypass_i changing after acceptance have no effect.
- Arithmetic is over GF(2^8), polynomial 0x11B.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 0x1B : 0).
  - Column bytes are s0..s3 (row 0..3).
  - MixColumns: out_r = 2·s_r ^ 3·s_(r+1) ^ s_(r+2) ^ s_(r+3), indices mod 4.
  - InvMixColumns: out_r = 0E·s_r ^ 0B·s_(r+1) ^ 0D·s_(r+2) ^ 09·s_(r+3).
  - Multiplications are built only from xtime chains and XORs; no lookup ROM.
- Columns not yet processed keep their captured value in the work register. data_o changes only in the DONE cycle.

Test Plan:
- Encrypt, data_i={4c31262d,d5d4d4d4,5c220af2,455313db}, decrypt_i=0, bypass_i=0 -> data_o={f8bd7e4d,d6d7d5d5,9d58dc9f,bca14d8e}; ready_o at T+6 for COLS_PER_CYCLE=1, and at T+4 / T+3 when rerun with 2 / 4.
- Decrypt, data_i={f8bd7e4d,d6d7d5d5,9d58dc9f,bca14d8e}, decrypt_i=1 -> data_o={4c31262d,d5d4d4d4,5c220af2,455313db}. Also data_i=all 0x01 bytes -> unchanged, in both modes.
- Bypass, data_i=00112233445566778899aabbccddeeff, bypass_i=1 -> data_o equals data_i, ready_o at T+2, busy_o high at T+1..T+2 only.
- Extra start pulses at T+2 and T+5 during an encrypt -> single ready_o at T+6 with the first result. A start at T+7 is accepted and its ready_o comes at T+13.
- rst asserted at T+3 with start_i=1 in the same cycle -> no ready_o; data_o=0, busy_o=0 from T+4; FSM idle. A later operation completes correctly.
